logic_gate_arbiter: RTL and testbench
=====================================

# logic_gate_arbiter

Shares one registered WIDTH-bit logic-gate unit (AND, OR, NOT, NAND, NOR, XOR, XNOR) among N_REQ requesters. Each requester presents an opcode and two operands on a valid/ready channel. A round-robin arbiter grants one request per cycle and executes it. The result is held in a single output register with its own valid/ready handshake, so back-to-back operations reach full throughput when the consumer is always ready.

## Interface
Parameters:
- WIDTH, 8: operand and result width in bits.
- N_REQ, 4: number of requesters, 2..8.
- ID_W, 3: requester-index width; must satisfy 2**ID_W >= N_REQ.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high.
- req_op  in  3*N_REQ  opcode; requester i uses bits [3i+2:3i].
- req_a  in  WIDTH*N_REQ  operand A; requester i uses slice i.
- req_b  in  WIDTH*N_REQ  operand B; requester i uses slice i.
- rsp_valid  out  1  result register holds a result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  WIDTH  result.
- rsp_id  out  ID_W  index of the requester that issued the result.
- rsp_err  out  1  the opcode was illegal.

## Operation
- Opcodes: 0 AND, 1 OR, 2 NOT A (B ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR. All operations are bitwise over WIDTH bits.
- Opcode 7 is illegal: rsp_data=0, rsp_err=1. The request still completes normally.
- Slot state is two-valued: EMPTY (rsp_valid=0) or FULL (rsp_valid=1).
- slot_free = !rsp_valid || rsp_ready.
- Grant rule: round-robin pointer ptr (ID_W bits). Search starts at ptr and wraps modulo N_REQ. The first i with req_valid[i] wins.
- req_ready[i] = slot_free && winner==i && !rst. This path is combinational from req_valid, rsp_valid and rsp_ready.
- A handshake occurs when req_valid[i] && req_ready[i]. On that edge:
  - rsp_data, rsp_id and rsp_err load;
  - rsp_valid becomes 1;
  - ptr becomes (i+1) mod N_REQ.
- Drain without a new grant: rsp_valid && rsp_ready with no handshake clears rsp_valid. rsp_data, rsp_id and rsp_err hold their old values.
- Simultaneous drain and grant: the result register is overwritten and rsp_valid stays 1. No bubble is inserted.
- A requester holds valid, op and operands stable until it sees ready. Dropping valid early is a protocol violation and its behaviour is unspecified.
- While FULL with rsp_ready=0, all req_ready are 0 and ptr does not move.
- ptr changes only on a handshake. Idle cycles leave it unchanged.

## Timing
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, ptr=0, all req_ready=0. Requester 0 has first priority after reset.
- Latency: a handshake at edge k makes the result visible from edge k through the next consumer handshake. This is 1 cycle from accept to rsp_valid.
- Throughput: 1 result per cycle with rsp_ready held high.
- Fairness: with all requesters continuously valid, each is granted exactly once every N_REQ grants.
- Reset mid-operation: a pending result is discarded without being delivered, and ptr returns to 0.

## Configuration
- LOGIC_GATE_ARB_STATS_EN compiles in extra ports and counters:
  - per-requester grant counters, exported as output grant_cnt, 16*N_REQ bits;
  - each counter is 16 bits and increments on that requester's handshake;
  - counters saturate at 16'hFFFF and are cleared by rst.
- Without the macro, the grant_cnt port and its counters do not exist. All other behaviour is identical.

## Structure
- Shared package logic_gate_pkg holds:
  - the opcode constants (OP_AND..OP_XNOR, OP_ILLEGAL=3'd7);
  - the opcode typedef (3-bit);
  - the stats counter width constant (16).
- Sub-module rr_arbiter (parameter N) takes a req vector, the ptr value and an enable. It returns a one-hot grant and the winner index. It contains no state.
- The ptr register, the opcode decode and the result register stay in logic_gate_arbiter.

## Test plan
All scenarios use WIDTH=8 and N_REQ=4.
- Single request: requester 2 sends op=5, a=8'hF0, b=8'h3C, with rsp_ready=1. Required: one cycle later rsp_data=8'hCC, rsp_id=2, rsp_err=0.
- Round-robin: all four requesters valid continuously, with rsp_ready=1 and starting from reset. Required: rsp_id sequence 0,1,2,3,0,1,… and no idle cycles.
- Backpressure: fill the slot, then hold rsp_ready=0 for 5 cycles with req_valid=4'b1111. Required: req_ready=0 throughout; rsp_data, rsp_id and ptr stable. Release ready: the next grant goes to (previous id+1).
- Opcode sweep and illegal opcode: a=8'hA5, b=8'h0F, op 0..7. Required rsp_data: 05, AF, 5A, FA, 50, AA, 55, 00. rsp_err=1 only for op=7.
- Reset during FULL: assert rst for 1 cycle while rsp_valid=1. Required: rsp_valid=0, all req_ready=0, and the next grant goes to requester 0 when all are valid.
- Stats (macro defined): 3 grants to requester 1. Required: grant_cnt slice 1 = 3. Also preload a counter to 16'hFFFF and grant once more: the counter stays 16'hFFFF.

Source files
------------

// File: rtl/logic_gate_pkg.sv
// ---------------------------------------------------------------------------
// logic_gate_pkg
// Shared definitions for the logic-gate arbiter:
//   - opcode typedef and opcode constants (OP_ILLEGAL is the one unused code)
//   - STATS_CNT_W : width of the optional per-requester grant counters
//                   (compiled in with LOGIC_GATE_ARB_STATS_EN)
// ---------------------------------------------------------------------------
package logic_gate_pkg;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_AND     = 3'd0;
    localparam opcode_t OP_OR      = 3'd1;
    localparam opcode_t OP_NOT     = 3'd2;
    localparam opcode_t OP_NAND    = 3'd3;
    localparam opcode_t OP_NOR     = 3'd4;
    localparam opcode_t OP_XOR     = 3'd5;
    localparam opcode_t OP_XNOR    = 3'd6;
    localparam opcode_t OP_ILLEGAL = 3'd7;

    localparam int STATS_CNT_W = 16;

endpackage

// File: rtl/logic_gate_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Stateless round-robin arbiter. Searches req_i starting at ptr_i, wrapping
// modulo N; the first set bit wins.
// Ports:
//   req_i     [N]     request vector
//   ptr_i     [ID_W]  search start index (always < N)
//   en_i              when low, no grant is issued
//   grant_o   [N]     one-hot grant (all zero when nothing granted)
//   winner_o  [ID_W]  index of the winning request (valid when any_o)
//   any_o             some request won
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 3
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    input  logic            en_i,
    output logic [N-1:0]    grant_o,
    output logic [ID_W-1:0] winner_o,
    output logic            any_o
);

    always_comb begin
        int idx;
        winner_o = '0;
        any_o    = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= N) idx = idx - N;
            if (!any_o && req_i[idx]) begin
                any_o    = 1'b1;
                winner_o = ID_W'(idx);
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_grant
        assign grant_o[gi] = en_i && any_o && (winner_o == ID_W'(gi));
    end

endmodule

// File: rtl/logic_gate_arbiter.sv
// ---------------------------------------------------------------------------
// logic_gate_arbiter
// One registered WIDTH-bit logic-gate unit shared by N_REQ requesters through
// a round-robin arbiter. The result register accepts a new result whenever it
// is empty or being drained in the same cycle, giving one result per cycle.
// Optional feature: define LOGIC_GATE_ARB_STATS_EN to add the grant_cnt port
// with saturating 16-bit per-requester grant counters.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  per-requester handshake (req_ready is one-hot or 0)
//   req_op, req_a, req_b packed per-requester opcode and operands
//   rsp_valid/rsp_ready  result handshake
//   rsp_data, rsp_id     result and issuing requester index
//   rsp_err              opcode was illegal (rsp_data forced to 0)
//   grant_cnt            (stats build only) 16 bits per requester
// ---------------------------------------------------------------------------
module logic_gate_arbiter
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4,
    parameter int ID_W  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [3*N_REQ-1:0]     req_op,
    input  logic [WIDTH*N_REQ-1:0] req_a,
    input  logic [WIDTH*N_REQ-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_err
`ifdef LOGIC_GATE_ARB_STATS_EN
    ,
    output logic [STATS_CNT_W*N_REQ-1:0] grant_cnt
`endif
);

    localparam int N_IDX = 2 ** ID_W;

    logic              rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]  rsp_data_q,  rsp_data_d;
    logic [ID_W-1:0]   rsp_id_q,    rsp_id_d;
    logic              rsp_err_q,   rsp_err_d;
    logic [ID_W-1:0]   ptr_q,       ptr_d;

    logic              slot_free;
    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   winner;
    logic              any_req;
    logic              hs;

    // Unpacked views sized to the full index range so that indexing by the
    // ID_W-bit winner is width-exact; slots beyond N_REQ read as zero.
    opcode_t           op_arr [N_IDX];
    logic [WIDTH-1:0]  a_arr  [N_IDX];
    logic [WIDTH-1:0]  b_arr  [N_IDX];

    for (genvar gi = 0; gi < N_IDX; gi++) begin : g_unpack
        if (gi < N_REQ) begin : g_real
            assign op_arr[gi] = req_op[3*gi +: 3];
            assign a_arr[gi]  = req_a[WIDTH*gi +: WIDTH];
            assign b_arr[gi]  = req_b[WIDTH*gi +: WIDTH];
        end else begin : g_pad
            assign op_arr[gi] = OP_AND;
            assign a_arr[gi]  = '0;
            assign b_arr[gi]  = '0;
        end
    end

    assign slot_free = !rsp_valid_q || rsp_ready;

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .req_i    (req_valid),
        .ptr_i    (ptr_q),
        .en_i     (slot_free && !rst),
        .grant_o  (grant),
        .winner_o (winner),
        .any_o    (any_req)
    );

    assign req_ready = grant;
    assign hs        = |grant;

    // Gate evaluation for the granted request.
    opcode_t          sel_op;
    logic [WIDTH-1:0] sel_a, sel_b, gate_res;
    assign sel_op = op_arr[winner];
    assign sel_a  = a_arr[winner];
    assign sel_b  = b_arr[winner];

    always_comb begin
        gate_res = '0;
        case (sel_op)
            OP_AND:  gate_res = sel_a & sel_b;
            OP_OR:   gate_res = sel_a | sel_b;
            OP_NOT:  gate_res = ~sel_a;
            OP_NAND: gate_res = ~(sel_a & sel_b);
            OP_NOR:  gate_res = ~(sel_a | sel_b);
            OP_XOR:  gate_res = sel_a ^ sel_b;
            OP_XNOR: gate_res = ~(sel_a ^ sel_b);
            default: gate_res = '0;
        endcase
    end

    // A grant overwrites the slot even while it is being drained, so no bubble.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        ptr_d       = ptr_q;
        if (hs) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = gate_res;
            rsp_id_d    = winner;
            rsp_err_d   = (sel_op == OP_ILLEGAL);
            ptr_d       = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
            ptr_q       <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            ptr_q       <= ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;

`ifdef LOGIC_GATE_ARB_STATS_EN
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stats
        logic [STATS_CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (grant[gi] && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        end

        always_ff @(posedge clk) begin
            if (rst) cnt_q <= '0;
            else     cnt_q <= cnt_d;
        end

        assign grant_cnt[STATS_CNT_W*gi +: STATS_CNT_W] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_logic_gate_arbiter.sv
// Randomized and directed bench for logic_gate_arbiter (WIDTH=8, N_REQ=4).
// A transaction-level model (pointer as an integer, search loop, gate rules)
// predicts req_ready and the result register every cycle.
module tb_logic_gate_arbiter;

    localparam int WIDTH = 8;
    localparam int N_REQ = 4;
    localparam int ID_W  = 3;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N_REQ-1:0]       req_valid = '0;
    logic [N_REQ-1:0]       req_ready;
    logic [3*N_REQ-1:0]     req_op = '0;
    logic [WIDTH*N_REQ-1:0] req_a = '0;
    logic [WIDTH*N_REQ-1:0] req_b = '0;
    logic                   rsp_valid;
    logic                   rsp_ready = 1'b0;
    logic [WIDTH-1:0]       rsp_data;
    logic [ID_W-1:0]        rsp_id;
    logic                   rsp_err;
`ifdef LOGIC_GATE_ARB_STATS_EN
    logic [16*N_REQ-1:0]    grant_cnt;
`endif

    logic_gate_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err)
`ifdef LOGIC_GATE_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Stimulus per requester
    logic [2:0]       op_t [N_REQ];
    logic [WIDTH-1:0] a_t  [N_REQ];
    logic [WIDTH-1:0] b_t  [N_REQ];

    // Reference model state
    int               m_ptr   = 0;
    logic             m_valid = 1'b0;
    logic [WIDTH-1:0] m_data  = '0;
    int               m_id    = 0;
    logic             m_err   = 1'b0;
    logic [N_REQ-1:0] exp_ready;

    function automatic logic [WIDTH-1:0] gate(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~a;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return a ^ b;
            3'd6: return ~(a ^ b);
            default: return '0;
        endcase
    endfunction

    // One cycle: called at a negedge, drives inputs, checks req_ready, advances
    // the model across the rising edge and checks the result at the next negedge.
    task automatic step(input logic [N_REQ-1:0] v, input logic rdy, input logic r);
        int win;
        rst       = r;
        req_valid = v;
        rsp_ready = rdy;
        for (int i = 0; i < N_REQ; i++) begin
            req_op[3*i +: 3]         = op_t[i];
            req_a[WIDTH*i +: WIDTH]  = a_t[i];
            req_b[WIDTH*i +: WIDTH]  = b_t[i];
        end
        #1;
        win = -1;
        exp_ready = '0;
        if (!r && (!m_valid || rdy)) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (win < 0 && v[(m_ptr + k) % N_REQ]) win = (m_ptr + k) % N_REQ;
            end
            if (win >= 0) exp_ready[win] = 1'b1;
        end
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        if (r) begin
            m_valid = 0; m_data = '0; m_id = 0; m_err = 0; m_ptr = 0;
        end else if (win >= 0) begin
            m_valid = 1'b1;
            m_data  = gate(op_t[win], a_t[win], b_t[win]);
            m_err   = (op_t[win] == 3'd7);
            m_id    = win;
            m_ptr   = (win + 1) % N_REQ;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        check("rsp_data",  32'(rsp_data),  32'(m_data));
        check("rsp_id",    32'(rsp_id),    32'(m_id));
        check("rsp_err",   32'(rsp_err),   32'(m_err));
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N_REQ; i++) begin
            op_t[i] = 3'($urandom_range(0, 7));
            a_t[i]  = 8'($urandom);
            b_t[i]  = 8'($urandom);
        end
    endtask

    logic [7:0] sweep_exp [8];
    logic [N_REQ-1:0] pend;

    initial begin
        sweep_exp[0] = 8'h05; sweep_exp[1] = 8'hAF; sweep_exp[2] = 8'h5A; sweep_exp[3] = 8'hFA;
        sweep_exp[4] = 8'h50; sweep_exp[5] = 8'hAA; sweep_exp[6] = 8'h55; sweep_exp[7] = 8'h00;
        rand_ops();
        @(negedge clk);

        // Reset state
        step('0, 1'b0, 1'b1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_data",  32'(rsp_data),  32'd0);
        step('0, 1'b1, 1'b0);

        // Single request from requester 2
        op_t[2] = 3'd5; a_t[2] = 8'hF0; b_t[2] = 8'h3C;
        step(4'b0100, 1'b1, 1'b0);
        check("single_data", 32'(rsp_data), 32'hCC);
        check("single_id",   32'(rsp_id),   32'd2);
        check("single_err",  32'(rsp_err),  32'd0);

        // Opcode sweep from requester 0
        step('0, 1'b1, 1'b1);
        for (int op = 0; op < 8; op++) begin
            op_t[0] = 3'(op); a_t[0] = 8'hA5; b_t[0] = 8'h0F;
            step(4'b0001, 1'b1, 1'b0);
            check("sweep_data", 32'(rsp_data), 32'(sweep_exp[op]));
            check("sweep_err",  32'(rsp_err),  32'(op == 7));
        end

        // Round-robin from reset, all valid, consumer always ready
        step('0, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            rand_ops();
            step(4'b1111, 1'b1, 1'b0);
            check("rr_id",    32'(rsp_id),    32'(k % N_REQ));
            check("rr_valid", 32'(rsp_valid), 32'd1);
        end

        // Backpressure: slot full (last id 3), consumer stalls 5 cycles
        for (int k = 0; k < 5; k++) begin
            rand_ops();
            step(4'b1111, 1'b0, 1'b0);
            check("bp_id", 32'(rsp_id), 32'd3);
        end
        step(4'b1111, 1'b1, 1'b0);
        check("bp_release_id", 32'(rsp_id), 32'd0);
        step(4'b1111, 1'b1, 1'b0);
        check("bp_next_id", 32'(rsp_id), 32'd1);

        // Reset while full
        step(4'b1111, 1'b1, 1'b1);
        check("rstfull_valid", 32'(rsp_valid), 32'd0);
        step(4'b1111, 1'b1, 1'b0);
        check("rstfull_next_id", 32'(rsp_id), 32'd0);

`ifdef LOGIC_GATE_ARB_STATS_EN
        step('0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(4'b0010, 1'b1, 1'b0);
        check("stats_cnt1", 32'(grant_cnt[31:16]), 32'd3);
        check("stats_cnt0", 32'(grant_cnt[15:0]),  32'd0);
`endif

        // Randomized traffic; requesters hold their request until accepted
        pend = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i] = 1'b1;
                    op_t[i] = 3'($urandom_range(0, 7));
                    a_t[i]  = 8'($urandom);
                    b_t[i]  = 8'($urandom);
                end
            end
            step(pend, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
            if (rst) pend = '0;
            else     pend = pend & ~exp_ready;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
